// File: rtl/float_class_arbiter_pkg.sv
// Shared definitions for the float class arbiter: class bit positions,
// exponent constant and output-stage state encoding.
package float_class_arbiter_pkg;

  localparam int CLS_ZERO = 0;
  localparam int CLS_NORM = 1;
  localparam int CLS_SUB  = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_NAN  = 4;
  localparam int NUM_CLS  = 5;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/float_class_arbiter_classify.sv
// Combinational IEEE-754 single-precision classifier producing a one-hot class.
// The sign bit does not affect the class, so only bits [30:0] are taken.
module float_class_arbiter_classify
  import float_class_arbiter_pkg::*;
(
  input  logic [30:0] data,
  output logic [4:0]  float_type
);

  logic [7:0]  exp_f;
  logic [22:0] man_f;

  assign exp_f = data[30:23];
  assign man_f = data[22:0];

  // Decode {exp all zero, exp all ones, mantissa zero} into exactly one class bit
  always_comb begin
    float_type = 5'b00000;
    case ({(exp_f == 8'h00), (exp_f == EXP_ALL_ONES), (man_f == 23'd0)})
      3'b101:  float_type[CLS_ZERO] = 1'b1;
      3'b100:  float_type[CLS_SUB]  = 1'b1;
      3'b011:  float_type[CLS_INF]  = 1'b1;
      3'b010:  float_type[CLS_NAN]  = 1'b1;
      default: float_type[CLS_NORM] = 1'b1;
    endcase
  end

endmodule

// File: rtl/float_class_arbiter.sv
// Two-requester round-robin front end for a shared float classifier, with a
// single registered result stage and per-class saturating completion counters.
module float_class_arbiter
  import float_class_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_type,
  output logic             out_sign,
  output logic             out_src,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_norm,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [CNT_W-1:0] cnt_inf,
  output logic [CNT_W-1:0] cnt_nan
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t           state;
  state_t           state_next;
  logic             rr_last;
  logic             can_accept;
  logic             accept;
  logic             grant;
  logic             out_hs;
  logic [31:0]      sel_data;
  logic [4:0]       sel_type;
  logic [CNT_W-1:0] cnt [NUM_CLS];

  // Round-robin grant; rr_last names the requester granted most recently
  always_comb begin
    can_accept = 1'b0;
    accept     = 1'b0;
    grant      = 1'b0;
    if (reset) begin
      can_accept = 1'b0;
    end else begin
      can_accept = (state == ST_EMPTY) || out_ready;
    end
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        accept = 1'b1;
        grant  = ~rr_last;
      end else if (req0_valid) begin
        accept = 1'b1;
        grant  = 1'b0;
      end else if (req1_valid) begin
        accept = 1'b1;
        grant  = 1'b1;
      end else begin
        accept = 1'b0;
        grant  = 1'b0;
      end
    end else begin
      accept = 1'b0;
      grant  = 1'b0;
    end
  end

  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;
  assign sel_data   = grant ? req1_data : req0_data;
  assign out_hs     = (state == ST_FULL) & out_ready;
  assign out_valid  = (state == ST_FULL);

  float_class_arbiter_classify u_classify (
    .data       (sel_data[30:0]),
    .float_type (sel_type)
  );

  // Output stage next state: refill wins over drain
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_FULL;
        end else begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept) begin
          state_next = ST_FULL;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end else begin
          state_next = ST_FULL;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Result register and round-robin pointer, loaded only on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      out_type <= 5'b00000;
      out_sign <= 1'b0;
      out_src  <= 1'b0;
      rr_last  <= 1'b1;
    end else if (accept) begin
      out_type <= sel_type;
      out_sign <= sel_data[31];
      out_src  <= grant;
      rr_last  <= grant;
    end
  end

  // Per-class completion counters; clear takes priority over a coincident count
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      for (int i = 0; i < NUM_CLS; i++) begin
        cnt[i] <= {CNT_W{1'b0}};
      end
    end else if (out_hs) begin
      for (int i = 0; i < NUM_CLS; i++) begin
        if (out_type[i]) begin
          cnt[i] <= sat_inc(cnt[i]);
        end
      end
    end
  end

  assign cnt_zero = cnt[CLS_ZERO];
  assign cnt_norm = cnt[CLS_NORM];
  assign cnt_sub  = cnt[CLS_SUB];
  assign cnt_inf  = cnt[CLS_INF];
  assign cnt_nan  = cnt[CLS_NAN];

endmodule
